fetch_queue: RTL and testbench

- Parametrised multi-entry instruction fetch queue between the instruction ROM and decode; replaces the single-register fetch stage buffer.
- Stores {pc, instr} pairs in a circular buffer with valid/ready handshakes on both sides, allowing fetch to run ahead of decode stalls.
- Synchronous flush support for redirects (branch mispredict, exception).

---
 rtl/cpu_pkg.sv | 13 +
 rtl/fetch_queue_mem.sv | 27 ++
 rtl/fetch_queue.sv | 96 +++++++++
 tb/tb_fetch_queue.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default datapath widths and the fetch entry
// record passed from fetch through the fetch queue to decode.
package cpu_pkg;

    localparam int CPU_ADDR_WIDTH  = 12;
    localparam int CPU_INSTR_WIDTH = 32;

    typedef struct packed {
        logic [CPU_ADDR_WIDTH-1:0]  pc;
        logic [CPU_INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Register-array storage for the fetch queue: one clocked write port and one
// asynchronous read port. Contents are deliberately left unreset.
module fetch_queue_mem
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CPU_ADDR_WIDTH + CPU_INSTR_WIDTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Circular fetch queue between instruction ROM and decode; {pc, instr} entries,
// valid/ready on both sides, synchronous flush for redirects.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH  = CPU_ADDR_WIDTH,
    parameter int INSTR_WIDTH = CPU_INSTR_WIDTH,
    parameter int DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_WIDTH-1:0]      in_pc,
    input  logic [INSTR_WIDTH-1:0]     in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_WIDTH-1:0]      out_pc,
    output logic [INSTR_WIDTH-1:0]     out_instr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = ADDR_WIDTH + INSTR_WIDTH;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty, full, push, pop;
    logic [EW-1:0] rdata;

    // Pointer MSB is the wrap bit: same index with differing wrap means full.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) &&
                   (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr_q[IW-1:0]),
        .wdata ({in_pc, in_instr}),
        .raddr (rd_ptr_q[IW-1:0]),
        .rdata (rdata)
    );

    assign out_pc    = empty ? '0 : rdata[EW-1:INSTR_WIDTH];
    assign out_instr = empty ? '0 : rdata[INSTR_WIDTH-1:0];
    assign count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a reference queue tracks accepted entries
// and every cycle's outputs are compared against it.
module tb_fetch_queue;
    import cpu_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic                       clk;
    logic                       rst;
    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    logic [CPU_ADDR_WIDTH-1:0]  in_pc;
    logic [CPU_INSTR_WIDTH-1:0] in_instr;
    logic                       out_valid;
    logic                       out_ready;
    logic [CPU_ADDR_WIDTH-1:0]  out_pc;
    logic [CPU_INSTR_WIDTH-1:0] out_instr;
    logic [CW-1:0]              count;

    fetch_queue #(
        .ADDR_WIDTH  (CPU_ADDR_WIDTH),
        .INSTR_WIDTH (CPU_INSTR_WIDTH),
        .DEPTH       (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    fetch_entry_t sb[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [CPU_INSTR_WIDTH-1:0] mk_instr(input logic [CPU_ADDR_WIDTH-1:0] pc);
        return 32'hC0DE_0000 ^ {20'h5A5A5, pc};
    endfunction

    task automatic check_outputs(input string ctx);
        fetch_entry_t head;
        head = (sb.size() > 0) ? sb[0] : '0;
        chk({ctx, ".count"},     64'(count),     64'(sb.size()));
        chk({ctx, ".in_ready"},  64'(in_ready),  64'(sb.size() < DEPTH));
        chk({ctx, ".out_valid"}, 64'(out_valid), 64'(sb.size() > 0));
        chk({ctx, ".out_pc"},    64'(out_pc),    64'(head.pc));
        chk({ctx, ".out_instr"}, 64'(out_instr), 64'(head.instr));
    endtask

    // Drives one cycle's inputs, checks the pre-edge outputs and advances the model.
    task automatic step(input string ctx, input logic v, input logic [CPU_ADDR_WIDTH-1:0] pc,
                        input logic ordy, input logic fl);
        logic mpush, mpop;
        fetch_entry_t e;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = mk_instr(pc);
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        check_outputs(ctx);
        mpush = v && (sb.size() < DEPTH);
        mpop  = ordy && (sb.size() > 0);
        if (fl) begin
            sb.delete();
        end else begin
            if (mpop) void'(sb.pop_front());
            if (mpush) begin
                e.pc    = pc;
                e.instr = mk_instr(pc);
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
        #3;
        check_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset asserted mid-cycle with idle queue
        #1 rst = 1'b1;
        #1 check_outputs("reset_mid");
        rst = 1'b0;
        @(posedge clk); #1;

        // Fill to full, refuse a fifth push, then drain in order
        for (int i = 0; i < 4; i++) step("fill", 1'b1, 12'(4*i), 1'b0, 1'b0);
        step("full_refuse", 1'b1, 12'd16, 1'b0, 1'b0);
        chk("full.count", 64'(count), 64'(4));
        chk("full.in_ready", 64'(in_ready), 64'(0));
        for (int i = 0; i < 4; i++) step("drain", 1'b0, 12'h0, 1'b1, 1'b0);
        step("drained", 1'b0, 12'h0, 1'b1, 1'b0);

        // Streaming across pointer wrap
        for (int i = 0; i < 20; i++) step("stream", 1'b1, 12'(4*i), 1'b1, 1'b0);
        step("stream_tail", 1'b0, 12'h0, 1'b1, 1'b0);
        step("stream_empty", 1'b0, 12'h0, 1'b1, 1'b0);

        // Full with simultaneous pop: push refused, then accepted next cycle
        for (int i = 0; i < 4; i++) step("fill2", 1'b1, 12'(12'h300 + 4*i), 1'b0, 1'b0);
        step("full_pop", 1'b1, 12'h310, 1'b1, 1'b0);
        chk("full_pop.count", 64'(count), 64'(3));
        step("full_repush", 1'b1, 12'h310, 1'b0, 1'b0);
        chk("full_repush.count", 64'(count), 64'(4));

        // Flush with a concurrent push drops everything
        step("pre_flush", 1'b0, 12'h0, 1'b1, 1'b0);
        step("flush", 1'b1, 12'h100, 1'b0, 1'b1);
        chk("flush.count", 64'(count), 64'(0));
        step("post_flush_push", 1'b1, 12'h200, 1'b0, 1'b0);
        step("post_flush_pop", 1'b0, 12'h0, 1'b1, 1'b0);
        step("post_flush_empty", 1'b0, 12'h0, 1'b1, 1'b0);

        // Async reset mid-stream
        step("pre_rst", 1'b1, 12'h500, 1'b0, 1'b0);
        step("pre_rst", 1'b1, 12'h504, 1'b0, 1'b0);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1 sb.delete();
        check_outputs("async_rst");
        rst = 1'b0;
        @(posedge clk); #1;
        step("post_rst_push", 1'b1, 12'h040, 1'b0, 1'b0);
        chk("post_rst.out_pc", 64'(out_pc), 64'(12'h040));
        step("post_rst_pop", 1'b0, 12'h0, 1'b1, 1'b0);
        step("post_rst_empty", 1'b0, 12'h0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
